noise_gate: RTL and testbench

- Stereo downward expander (noise gate) on the 32-bit signed sample path. It is the low-level counterpart of the distortion stage: distortion compresses peaks, and this block attenuates material below a threshold.
- Sits between the codec receive path and the effects chain.
- Sequential: per-sample peak envelope follower, gate FSM with hold counter, and a ramped gain applied through a 3-stage valid pipeline.

---
 rtl/noise_gate.sv | 214 +++++++++++++++++++++
 tb/tb_noise_gate.sv | 200 ++++++++++++++++++++
 2 files changed

// File: rtl/noise_gate.sv
// noise_gate: stereo downward expander on the 32-bit signed sample path.
//
// A peak envelope follower drives a five-state gate (CLOSED, ATTACK, OPEN,
// HOLD, RELEASE). The gate produces a 0..256 gain that scales both channels.
// Everything runs in a three-stage pipeline:
//   S1: capture the samples and update the envelope.
//   S2: FSM step and gain update from the envelope register.
//   S3: registered output = (sample * gain) >>> 8.
//
// Handshake: in_valid and out_valid are one-cycle strobes with no
// backpressure. A sample presented with in_valid at edge N appears with
// out_valid in the cycle after edge N+2. Back-to-back samples are accepted.
//
// Ports:
//   CLOCK_50   in   system clock
//   resetn     in   asynchronous active-low reset
//   enable     in   1 = gate active, 0 = bypass (unity gain, FSM parked in OPEN)
//   in_valid   in   strobe qualifying in_L / in_R
//   in_L/in_R  in   signed 32-bit samples
//   out_valid  out  strobe qualifying out_L / out_R
//   out_L/R    out  signed 32-bit gated samples
//   gate_open  out  registered; high while the FSM is in ATTACK, OPEN or HOLD
module noise_gate #(
    parameter logic [31:0] OPEN_THRESH  = 32'd4000000,
    parameter logic [31:0] CLOSE_THRESH = 32'd2000000,
    parameter int          HOLD_SAMPLES = 2400,
    parameter int          ATTACK_STEP  = 32,
    parameter int          RELEASE_STEP = 2,
    parameter int          DECAY_SHIFT  = 10
) (
    input  logic               CLOCK_50,
    input  logic               resetn,
    input  logic               enable,
    input  logic               in_valid,
    input  logic signed [31:0] in_L,
    input  logic signed [31:0] in_R,
    output logic               out_valid,
    output logic signed [31:0] out_L,
    output logic signed [31:0] out_R,
    output logic               gate_open
);

    localparam int         HW       = (HOLD_SAMPLES > 1) ? $clog2(HOLD_SAMPLES) : 1;
    localparam logic [8:0] GAIN_MAX = 9'd256;

    typedef enum logic [2:0] {
        ST_CLOSED, ST_ATTACK, ST_OPEN, ST_HOLD, ST_RELEASE
    } state_t;

    // Magnitude as an unsigned 31-bit value; -2^31 has no positive twin, so it saturates.
    function automatic logic [30:0] mag31(input logic signed [31:0] x);
        logic [31:0] neg;
        neg = -x;
        if (x[31] && (x[30:0] == 31'd0)) return 31'h7fff_ffff;
        else if (x[31])                  return neg[30:0];
        else                             return x[30:0];
    endfunction

    // ---------------- S1: sample capture and envelope ----------------
    logic               s1_valid;
    logic signed [31:0] s1_L, s1_R;
    logic [30:0]        env;
    logic [30:0]        mag_l, mag_r, abs_max, env_decay, env_next;

    always_comb begin
        mag_l     = mag31(in_L);
        mag_r     = mag31(in_R);
        abs_max   = (mag_l > mag_r) ? mag_l : mag_r;
        env_decay = env - (env >> DECAY_SHIFT);
        env_next  = (abs_max > env_decay) ? abs_max : env_decay;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            s1_valid <= 1'b0;
            s1_L     <= '0;
            s1_R     <= '0;
            env      <= '0;
        end else begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_L <= in_L;
                s1_R <= in_R;
                env  <= env_next;
            end
        end
    end

    // ---------------- S2: gate FSM and gain ----------------
    state_t             state, state_nx;
    logic [8:0]         gain, gain_nx;
    logic [HW-1:0]      hold_cnt, hold_nx;
    logic               gate_nx;
    logic               s2_valid;
    logic signed [31:0] s2_L, s2_R;
    logic [9:0]         gain_up;
    logic [8:0]         gain_up_sat, gain_dn_sat;
    logic               env_ge_open, env_lt_close;

    always_comb begin
        state_nx     = state;
        gain_nx      = gain;
        hold_nx      = hold_cnt;
        gain_up      = {1'b0, gain} + 10'(ATTACK_STEP);
        gain_up_sat  = (gain_up >= {1'b0, GAIN_MAX}) ? GAIN_MAX : gain_up[8:0];
        gain_dn_sat  = (gain <= 9'(RELEASE_STEP)) ? 9'd0 : gain - 9'(RELEASE_STEP);
        env_ge_open  = {1'b0, env} >= OPEN_THRESH;
        env_lt_close = {1'b0, env} < CLOSE_THRESH;

        if (s1_valid) begin
            if (!enable) begin
                // Park in OPEN at unity so re-enabling produces no gain step.
                state_nx = ST_OPEN;
                gain_nx  = GAIN_MAX;
                hold_nx  = '0;
            end else begin
                case (state)
                    ST_CLOSED: begin
                        gain_nx = 9'd0;
                        if (env_ge_open) begin
                            state_nx = ST_ATTACK;
                            gain_nx  = gain_up_sat;
                        end
                    end
                    ST_ATTACK: begin
                        gain_nx = gain_up_sat;
                        if (gain_up_sat == GAIN_MAX) state_nx = ST_OPEN;
                    end
                    ST_OPEN: begin
                        gain_nx = GAIN_MAX;
                        if (env_lt_close) begin
                            state_nx = ST_HOLD;
                            hold_nx  = HW'(HOLD_SAMPLES - 1);
                        end
                    end
                    ST_HOLD: begin
                        gain_nx = GAIN_MAX;
                        // Reopen takes priority over hold expiry.
                        if (env_ge_open)           state_nx = ST_OPEN;
                        else if (hold_cnt == '0)   state_nx = ST_RELEASE;
                        else                       hold_nx  = hold_cnt - 1'b1;
                    end
                    ST_RELEASE: begin
                        // On reopen the ramp restarts from the current gain next sample.
                        if (env_ge_open) begin
                            state_nx = ST_ATTACK;
                        end else begin
                            gain_nx = gain_dn_sat;
                            if (gain_dn_sat == 9'd0) state_nx = ST_CLOSED;
                        end
                    end
                    default: begin
                        state_nx = ST_CLOSED;
                        gain_nx  = 9'd0;
                        hold_nx  = '0;
                    end
                endcase
            end
        end

        gate_nx = (state_nx == ST_ATTACK) || (state_nx == ST_OPEN) || (state_nx == ST_HOLD);
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state     <= ST_CLOSED;
            gain      <= 9'd0;
            hold_cnt  <= '0;
            gate_open <= 1'b0;
            s2_valid  <= 1'b0;
            s2_L      <= '0;
            s2_R      <= '0;
        end else begin
            state     <= state_nx;
            gain      <= gain_nx;
            hold_cnt  <= hold_nx;
            gate_open <= gate_nx;
            s2_valid  <= s1_valid;
            if (s1_valid) begin
                s2_L <= s1_L;
                s2_R <= s1_R;
            end
        end
    end

    // ---------------- S3: apply gain ----------------
    // 41-bit signed product; gain <= 256 keeps bits [39:8] free of overflow.
    logic [8:0]         gain_eff;
    logic signed [40:0] a_l, a_r, g_ext, prod_l, prod_r;

    always_comb begin
        gain_eff = enable ? gain : GAIN_MAX;
        a_l      = {{9{s2_L[31]}}, s2_L};
        a_r      = {{9{s2_R[31]}}, s2_R};
        g_ext    = {32'd0, gain_eff};
        prod_l   = a_l * g_ext;
        prod_r   = a_r * g_ext;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            out_valid <= 1'b0;
            out_L     <= '0;
            out_R     <= '0;
        end else begin
            out_valid <= s2_valid;
            if (s2_valid) begin
                out_L <= prod_l[39:8];
                out_R <= prod_r[39:8];
            end
        end
    end

endmodule

// File: tb/tb_noise_gate.sv
// Directed bench for noise_gate. The gate runs with DECAY_SHIFT=2 and
// HOLD_SAMPLES=4 so that hold and release complete in a short run. A table of
// single-sample vectors covers the steady-state behaviour; hand-written
// sequences cover mid-stream reset, bypass and back-to-back streaming.
module tb_noise_gate;

    logic               clk;
    logic               resetn;
    logic               enable;
    logic               in_valid;
    logic signed [31:0] in_L, in_R;
    logic               out_valid;
    logic signed [31:0] out_L, out_R;
    logic               gate_open;

    int n_tests = 0;
    int n_fail  = 0;

    noise_gate #(
        .OPEN_THRESH (32'd4000000),
        .CLOSE_THRESH(32'd2000000),
        .HOLD_SAMPLES(4),
        .ATTACK_STEP (32),
        .RELEASE_STEP(2),
        .DECAY_SHIFT (2)
    ) dut (
        .CLOCK_50 (clk),
        .resetn   (resetn),
        .enable   (enable),
        .in_valid (in_valid),
        .in_L     (in_L),
        .in_R     (in_R),
        .out_valid(out_valid),
        .out_L    (out_L),
        .out_R    (out_R),
        .gate_open(gate_open)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #10 clk = ~clk;

    // ---------------- vector table ----------------
    typedef struct {
        logic               en;
        logic signed [31:0] l;
        logic signed [31:0] r;
        logic signed [31:0] exp_l;
        logic signed [31:0] exp_r;
        logic               exp_gate;
    } vec_t;

    vec_t vecs[$];

    function automatic void add(input logic en, input logic signed [31:0] l, r,
                                input logic signed [31:0] el, er, input logic eg);
        vec_t v;
        v.en = en; v.l = l; v.r = r; v.exp_l = el; v.exp_r = er; v.exp_gate = eg;
        vecs.push_back(v);
    endfunction

    // ---------------- checker ----------------
    task automatic chk(input string name, input longint act, input longint exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // One isolated sample: check the strobe is quiet for two edges, gate_open
    // after S2, and the gated output after S3.
    task automatic send(input logic en, input logic signed [31:0] l, r,
                        input logic signed [31:0] el, er, input logic eg, input string tag);
        @(negedge clk);
        enable = en; in_valid = 1'b1; in_L = l; in_R = r;
        @(posedge clk); #1;
        chk($sformatf("%s_ov_e0", tag), longint'(out_valid), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk($sformatf("%s_ov_e1", tag), longint'(out_valid), 0);
        chk($sformatf("%s_gate", tag), longint'(gate_open), longint'(eg));
        @(posedge clk); #1;
        chk($sformatf("%s_ov_e2", tag), longint'(out_valid), 1);
        chk($sformatf("%s_out_l", tag), longint'(out_L), longint'(el));
        chk($sformatf("%s_out_r", tag), longint'(out_R), longint'(er));
    endtask

    // ---------------- test ----------------
    initial begin
        longint g, el, er;

        // Below threshold: 20 samples of 1M stay gated to 0.
        for (int i = 0; i < 20; i++) add(1, 1000000, 1000000, 0, 0, 0);
        // Attack from CLOSED: gain 32, 64, ..., 256.
        for (int k = 1; k <= 9; k++) begin
            g = (k >= 8) ? 256 : 32 * k;
            add(1, 10000000, -5000000, 32'(10000000 * g / 256), 32'(-5000000 * g / 256), 1);
        end
        // Hold: env crosses below 2M on sample 6, four hold samples, RELEASE entered on sample 10.
        for (int k = 1; k <= 9; k++) add(1, 1000000, -1000000, 1000000, -1000000, 1);
        add(1, 1000000, -1000000, 1000000, -1000000, 0);
        add(1, 1000000, -1000000, 992187, -992188, 0);
        add(1, 1000000, -1000000, 984375, -984375, 0);
        // Rest of the release ramp down to 0 (gain 256-2k), floor rounding on the negative side.
        for (int k = 3; k <= 128; k++) begin
            g  = 256 - 2 * k;
            el = (64'sd1000000 * g) >>> 8;
            er = (-64'sd1000000 * g) >>> 8;
            add(1, 1000000, -1000000, 32'(el), 32'(er), 0);
        end
        add(1, 1000000, -1000000, 0, 0, 0);
        add(1, 1000000, -1000000, 0, 0, 0);
        // Reopen for the full-scale case.
        for (int k = 1; k <= 8; k++)
            add(1, 10000000, -5000000, 32'(1250000 * k), 32'(-625000 * k), 1);
        add(1, 32'sh8000_0000, 32'sh7fff_ffff, 32'sh8000_0000, 32'sh7fff_ffff, 1);
        // Envelope saturated at 2^31-1 keeps the gate open through a dozen silent samples.
        for (int k = 0; k < 12; k++) add(1, 0, 0, 0, 0, 1);

        // Reset state.
        resetn = 1'b0; enable = 1'b1; in_valid = 1'b0; in_L = '0; in_R = '0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_ov",   longint'(out_valid), 0);
        chk("rst_outl", longint'(out_L), 0);
        chk("rst_outr", longint'(out_R), 0);
        chk("rst_gate", longint'(gate_open), 0);
        @(negedge clk);
        resetn = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            send(vecs[i].en, vecs[i].l, vecs[i].r, vecs[i].exp_l, vecs[i].exp_r,
                 vecs[i].exp_gate, $sformatf("v%0d", i));

        // Mid-stream reset with the gate open at unity.
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            in_valid = 1'b1; in_L = 3000000; in_R = -3000000;
            @(posedge clk); #1;
            if (c >= 2) begin
                chk($sformatf("strm%0d_ov", c), longint'(out_valid), 1);
                chk($sformatf("strm%0d_outl", c), longint'(out_L), 3000000);
                chk($sformatf("strm%0d_gate", c), longint'(gate_open), 1);
            end
        end
        #3 resetn = 1'b0;
        #1;
        chk("mrst_ov",   longint'(out_valid), 0);
        chk("mrst_outl", longint'(out_L), 0);
        chk("mrst_outr", longint'(out_R), 0);
        chk("mrst_gate", longint'(gate_open), 0);
        @(negedge clk);
        in_valid = 1'b0;
        @(negedge clk);
        resetn = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("flush%0d_ov", c), longint'(out_valid), 0);
        end
        // First sample after reset starts from CLOSED: gain 32.
        send(1, 10000000, -5000000, 1250000, -625000, 1, "post_rst");

        // Bypass forces unity and parks the FSM in OPEN; re-enable continues at unity.
        send(0, 1000, -7, 1000, -7, 1, "byp");
        send(1, 1000, -7, 1000, -7, 1, "reen");

        // Bypass streaming: three back-to-back samples, fixed two-edge latency.
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            enable   = 1'b0;
            in_valid = (c < 3);
            in_L     = c + 1;
            in_R     = -(c + 1);
            @(posedge clk); #1;
            if (c >= 2 && c <= 4) begin
                chk($sformatf("bstrm%0d_ov", c), longint'(out_valid), 1);
                chk($sformatf("bstrm%0d_outl", c), longint'(out_L), c - 1);
                chk($sformatf("bstrm%0d_outr", c), longint'(out_R), -(c - 1));
            end else begin
                chk($sformatf("bstrm%0d_ov", c), longint'(out_valid), 0);
            end
        end
        enable = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #2000000;
        $display("FAIL timeout: got %0d expected %0d", 0, 1);
        n_fail++;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $fatal(1, "timeout");
    end

endmodule
